// File: rtl/song_reader_pkg.sv
// Shared music player defines: field widths, end-of-song marker and the
// song_reader sequencer state encodings.
package song_reader_pkg;

  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = 5;
  localparam int SONG_W = 2;
  localparam int ADDR_W = SONG_W + IDX_W;
  localparam int ROM_W  = NOTE_W + DUR_W;

  localparam logic [DUR_W-1:0] END_MARKER = '0;
  localparam logic [IDX_W-1:0] IDX_LAST   = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_PLAYING = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic logic is_end_marker(input logic [DUR_W-1:0] dur);
    return dur == END_MARKER;
  endfunction

endpackage

// File: rtl/song_reader.sv
// Song sequencer: walks one song in the external ROM note by note, hands each
// note to the duration counter and waits for its done pulse before advancing.
module song_reader
  import song_reader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    note_done,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [ROM_W-1:0]        rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    new_note,
  output logic                    song_done
);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              pend_q, pend_d;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = rom_data[ROM_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    song_d  = song_q;
    note_d  = note_q;
    dur_d   = dur_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (play) begin
          song_d  = song;
          index_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (play) state_d = S_CHECK;
      end
      S_CHECK: begin
        // rom_addr is held while paused, so rom_data stays valid here
        if (play) begin
          if (is_end_marker(rom_dur)) begin
            state_d = S_DONE;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (play) state_d = S_PLAYING;
      end
      S_PLAYING: begin
        // a done pulse seen while paused is remembered and replayed on resume
        if (!play) begin
          if (note_done) pend_d = 1'b1;
        end else if (note_done || pend_q) begin
          pend_d = 1'b0;
          if (index_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        index_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      song_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      song_q  <= song_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      pend_q  <= pend_d;
    end
  end

  // new_note is gated by play so a paused LOAD stays silent until resume
  assign new_note  = (state_q == S_LOAD) && play;
  assign song_done = (state_q == S_DONE);
  assign rom_addr  = {song_q, index_q};
  assign note      = note_q;
  assign duration  = dur_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: directed latency/pause/reset steps, then random songs
// checked against a note-list model derived from the ROM contents.
module tb_song_reader;
  import song_reader_pkg::*;

  logic              clk = 1'b0;
  logic              reset, play, note_done;
  logic [SONG_W-1:0] song;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_data;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note, song_done;

  logic [ROM_W-1:0]  mem [0:(1<<ADDR_W)-1];

  int vectors = 0;
  int miscompares = 0;

  logic              o_new, o_done;
  logic [NOTE_W-1:0] o_note;
  logic [DUR_W-1:0]  o_dur;
  logic [ADDR_W-1:0] o_addr;

  logic [ROM_W-1:0]  exp_q [$];
  logic [ROM_W-1:0]  exp_e;
  logic [SONG_W-1:0] s;
  logic              p, nd, gap, fin;
  int cd, nn, done_cnt, new_cnt, done_at, last_nd, max_addr;

  song_reader dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .duration(duration),
    .new_note(new_note), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // synchronous song ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= mem[rom_addr];

  function automatic logic [ADDR_W-1:0] ad(input logic [SONG_W-1:0] sg, input int i);
    logic [IDX_W-1:0] x;
    x = i[IDX_W-1:0];
    return {sg, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("compare %s wrong", tag);
    end
  endtask

  // drive inputs just after the edge, sample on the falling edge
  task automatic cycle(input logic pl, input logic ndn);
    play = pl;
    note_done = ndn;
    @(negedge clk);
    o_new  = new_note;
    o_done = song_done;
    o_note = note;
    o_dur  = duration;
    o_addr = rom_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; play = 1'b0; note_done = 1'b0; song = '0;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = {NOTE_W'($urandom), DUR_W'($urandom_range(1, 63))};
    @(posedge clk); #1;
    cycle(0, 0); cycle(0, 0);
    reset = 1'b0;

    // reset state
    cycle(0, 0);
    check("rst_new_note", o_new, 0);
    check("rst_song_done", o_done, 0);
    check("rst_note", o_note, 0);
    check("rst_duration", o_dur, 0);
    check("rst_rom_addr", o_addr, 0);

    // first note latency
    mem[ad(1, 0)] = {6'd20, 6'd8};
    mem[ad(1, 1)] = {6'd33, 6'd4};
    mem[ad(1, 2)] = {6'd17, 6'd0};
    song = 2'd1;
    cycle(1, 0);
    song = 2'd2;
    cycle(1, 0);
    check("fetch_addr", o_addr, 7'h20);
    check("fetch_no_new", o_new, 0);
    cycle(1, 0);
    check("check_no_new", o_new, 0);
    cycle(1, 0);
    check("load_new", o_new, 1);
    check("load_note", o_note, 20);
    check("load_dur", o_dur, 8);
    cycle(1, 0);
    check("playing_no_new", o_new, 0);
    cycle(1, 0);
    check("playing_hold_addr", o_addr, 7'h20);

    // advance to second note
    cycle(1, 1);
    cycle(1, 0);
    check("adv_addr", o_addr, 7'h21);
    check("adv_no_new1", o_new, 0);
    cycle(1, 0);
    check("adv_no_new2", o_new, 0);
    cycle(1, 0);
    check("adv_new", o_new, 1);
    check("adv_note", o_note, 33);
    check("adv_dur", o_dur, 4);
    cycle(1, 0);

    // end marker
    cycle(1, 1);
    done_cnt = 0; new_cnt = 0; done_at = -1;
    for (int j = 1; j <= 6; j++) begin
      cycle(j <= 2, 0);
      if (o_done) begin done_cnt++; done_at = j; end
      if (o_new) new_cnt++;
      if (j == 4) check("idle_addr", o_addr, 7'h20);
    end
    check("marker_done_cnt", done_cnt, 1);
    check("marker_done_cycle", done_at, 3);
    check("marker_no_new", new_cnt, 0);
    check("marker_note_kept", o_note, 33);
    check("marker_dur_kept", o_dur, 4);

    // full 32-note song, no marker
    for (int i = 0; i < 32; i++) mem[ad(1, i)] = {NOTE_W'(i + 1), DUR_W'((i % 7) + 1)};
    song = 2'd1;
    cd = -1; nn = 0; done_at = -1; last_nd = -2; max_addr = 0;
    for (int c = 0; c < 400; c++) begin
      nd = (cd == 0);
      cycle(1, nd);
      if (nd) last_nd = c;
      cd = (cd > 0) ? cd - 1 : -1;
      if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
      if (o_new) begin
        check("full_note", o_note, nn + 1);
        check("full_dur", o_dur, (nn % 7) + 1);
        nn++;
        cd = 2;
      end
      if (o_done) begin done_at = c; break; end
    end
    cycle(0, 0);
    check("full_new_count", nn, 32);
    check("full_done_after_last", done_at, last_nd + 1);
    check("full_max_addr", max_addr, 7'h3F);

    // pause with note_done while paused
    for (int i = 0; i < 3; i++) mem[ad(3, i)] = {NOTE_W'(40 + i), 6'd3};
    mem[ad(3, 3)] = {6'd9, 6'd0};
    song = 2'd3;
    cycle(1, 0);
    nn = 0;
    for (int c = 0; c < 10 && nn == 0; c++) begin
      cycle(1, 0);
      if (o_new) nn = 1;
    end
    check("pause_first_new", nn, 1);
    cycle(1, 0);
    cycle(0, 1);
    new_cnt = 0;
    for (int j = 0; j < 4; j++) begin
      cycle(0, 0);
      if (o_new) new_cnt++;
    end
    check("pause_no_new", new_cnt, 0);
    check("pause_addr_hold", o_addr, 7'h60);
    cycle(1, 0);
    cycle(1, 0);
    check("resume_addr", o_addr, 7'h61);
    check("resume_no_new1", o_new, 0);
    cycle(1, 0);
    check("resume_no_new2", o_new, 0);
    cycle(1, 0);
    check("resume_new", o_new, 1);
    check("resume_note", o_note, 41);
    new_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      cycle(1, 0);
      if (o_new) new_cnt++;
    end
    check("resume_single_adv_new", new_cnt, 0);
    check("resume_single_adv_addr", o_addr, 7'h61);
    reset = 1'b1;
    cycle(0, 0);
    reset = 1'b0;

    // reset mid-song at index 7
    for (int i = 0; i < 32; i++) mem[ad(2, i)] = {NOTE_W'(i), 6'd5};
    song = 2'd2;
    cycle(1, 0);
    nn = 0; cd = -1;
    for (int c = 0; c < 200 && nn < 8; c++) begin
      nd = (cd == 0);
      cycle(1, nd);
      cd = (cd > 0) ? cd - 1 : -1;
      if (o_new) begin nn++; cd = 1; end
    end
    cycle(1, 0);
    check("rstmid_addr_idx7", o_addr, 7'h47);
    reset = 1'b1;
    cycle(1, 0);
    reset = 1'b0;
    cycle(0, 0);
    check("rstmid_new", o_new, 0);
    check("rstmid_addr", o_addr, 0);
    check("rstmid_note", o_note, 0);
    done_cnt = o_done ? 1 : 0;
    for (int j = 0; j < 5; j++) begin
      cycle(0, 0);
      if (o_done) done_cnt++;
    end
    check("rstmid_no_done", done_cnt, 0);

    // random songs against the note-list model
    for (int t = 0; t < 12; t++) begin
      s = SONG_W'($urandom);
      for (int i = 0; i < 32; i++)
        mem[ad(s, i)] = {NOTE_W'($urandom),
                         (t % 4 != 0 && $urandom_range(0, 9) == 0) ? 6'd0 : DUR_W'($urandom_range(1, 63))};
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
        if (mem[ad(s, i)][DUR_W-1:0] == 0) break;
        exp_q.push_back(mem[ad(s, i)]);
      end
      song = s;
      cycle(1, 0);
      cd = -1; gap = 1'b1; fin = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        p  = ($urandom_range(0, 4) != 0);
        nd = (cd == 0) || (gap && $urandom_range(0, 5) == 0);
        song = SONG_W'($urandom);
        cycle(p, nd);
        if (cd == 0) begin cd = -1; gap = 1'b1; end
        else if (cd > 0) cd--;
        if (o_new) begin
          check("rnd_song_bits", o_addr[ADDR_W-1:IDX_W], s);
          if (exp_q.size() == 0) begin
            check("rnd_unexpected_note", 1, 0);
          end else begin
            exp_e = exp_q.pop_front();
            check("rnd_note", o_note, exp_e[ROM_W-1:DUR_W]);
            check("rnd_dur", o_dur, exp_e[DUR_W-1:0]);
          end
          gap = 1'b0;
          cd = $urandom_range(0, 4);
        end
        if (o_done) begin
          check("rnd_all_notes_played", exp_q.size(), 0);
          fin = 1'b1;
          break;
        end
      end
      check("rnd_song_finished", fin, 1);
      cycle(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
